fetch_pc_ctrl: RTL

//  Consumer end of the EX-stage branch resolution interface. Takes jump/target from
//  the resolver, owns the word-addressed fetch PC, drives instruction-memory fetch,
//  and kills wrong-path instructions fetched before the redirect lands.

---
 rtl/fetch_pc_ctrl_pkg.sv | 22 ++
 rtl/fetch_pc_ctrl_if.sv | 30 +++
 rtl/fetch_pc_ctrl_fetch_valid_pipe.sv | 44 ++++
 rtl/fetch_pc_ctrl.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/fetch_pc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pc_ctrl_pkg
// Brief    : Shared types and constants for the fetch PC controller.
// Revision : 1.0  initial release
// ============================================================================
package fetch_pc_ctrl_pkg;

    localparam int          DEFAULT_PC_W     = 32;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int          IMEM_LAT_MAX     = 4;
    // Wide enough to hold any legal kill window length.
    localparam int          KILL_CNT_W       = $clog2(IMEM_LAT_MAX + 1);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_KILL = 2'd1,
        ST_PEND = 2'd2
    } fetch_state_t;

endpackage : fetch_pc_ctrl_pkg
`default_nettype wire

// File: rtl/fetch_pc_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pc_ctrl_if
// Brief    : Branch-resolution / instruction-fetch bundle around the fetch PC
//            controller. slave = controller side, master = environment side.
// Revision : 1.0  initial release
// ============================================================================
interface fetch_pc_ctrl_if #(
    parameter int PC_W = 32
) ();
    logic            jump_i;
    logic [PC_W-1:0] next_i;
    logic            ex_valid_i;
    logic            imem_ready_i;
    logic [PC_W-1:0] pc_o;
    logic            fetch_req_o;
    logic            fetch_valid_o;
    logic            flush_o;

    modport slave (
        input  jump_i, next_i, ex_valid_i, imem_ready_i,
        output pc_o, fetch_req_o, fetch_valid_o, flush_o
    );

    modport master (
        output jump_i, next_i, ex_valid_i, imem_ready_i,
        input  pc_o, fetch_req_o, fetch_valid_o, flush_o
    );
endinterface : fetch_pc_ctrl_if
`default_nettype wire

// File: rtl/fetch_pc_ctrl_fetch_valid_pipe.sv
`default_nettype none
// ============================================================================
// Module   : fetch_valid_pipe
// Brief    : DEPTH-stage valid shift register tracking in-flight imem reads.
//            kill_i synchronously empties every stage.
// Revision : 1.0  initial release
// ============================================================================
module fetch_valid_pipe #(
    parameter int DEPTH = 1
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic in_valid_i,
    input  wire logic kill_i,
    output logic      out_valid_o
);

    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;

    // Shift one stage per cycle; a kill drops everything in flight.
    always_comb begin
        valid_d = '0;
        if (!kill_i) begin
            valid_d[0] = in_valid_i;
            for (int i = 1; i < DEPTH; i++) begin
                valid_d[i] = valid_q[i-1];
            end
        end
    end

    // Stage registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    assign out_valid_o = valid_q[DEPTH-1];

endmodule : fetch_valid_pipe
`default_nettype wire

// File: rtl/fetch_pc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pc_ctrl
// Brief    : Owns the word-addressed fetch PC, applies EX-stage redirects,
//            holds a redirect while imem is busy, and masks wrong-path fetch
//            data for IMEM_LAT accepted fetches after a redirect lands.
//            Optional macro PC_REDIRECT_COUNT_EN adds redirect_cnt_o, a
//            saturating count of honoured redirects.
// Revision : 1.0  initial release
// ============================================================================
module fetch_pc_ctrl
    import fetch_pc_ctrl_pkg::*;
#(
    parameter int              PC_W     = DEFAULT_PC_W,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(DEFAULT_RESET_PC),
    parameter int              IMEM_LAT = 1
) (
    input  wire logic      clk,
    input  wire logic      rst,
    fetch_pc_ctrl_if.slave bus
`ifdef PC_REDIRECT_COUNT_EN
    ,
    output logic [31:0]    redirect_cnt_o
`endif
);

    localparam logic [KILL_CNT_W-1:0] KILL_LOAD = KILL_CNT_W'(IMEM_LAT);

    fetch_state_t          state_q, state_d;
    logic [PC_W-1:0]       pc_q, pc_d;
    logic [PC_W-1:0]       pend_target_q, pend_target_d;
    logic                  pend_v_q, pend_v_d;
    logic [KILL_CNT_W-1:0] kill_cnt_q, kill_cnt_d;

    logic redir;
    logic accept;
    logic pipe_valid;

    assign redir  = bus.jump_i & bus.ex_valid_i;
    // Requests are withheld during reset and while a redirect waits for imem.
    assign accept = bus.fetch_req_o & bus.imem_ready_i;

    // Next-state, PC and kill-window computation.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pend_target_d = pend_target_q;
        pend_v_d      = pend_v_q;
        kill_cnt_d    = kill_cnt_q;
        case (state_q)
            ST_PEND: begin
                if (bus.imem_ready_i) begin
                    // A redirect arriving in the same cycle is newer than the stored one.
                    pc_d       = redir ? bus.next_i : pend_target_q;
                    pend_v_d   = 1'b0;
                    kill_cnt_d = KILL_LOAD;
                    state_d    = ST_KILL;
                end else if (redir) begin
                    pend_target_d = bus.next_i;
                end
            end
            default: begin
                if (redir) begin
                    if (bus.imem_ready_i) begin
                        pc_d       = bus.next_i;
                        kill_cnt_d = KILL_LOAD;
                        state_d    = ST_KILL;
                    end else begin
                        pend_target_d = bus.next_i;
                        pend_v_d      = 1'b1;
                        kill_cnt_d    = '0;
                        state_d       = ST_PEND;
                    end
                end else if (accept) begin
                    pc_d = pc_q + PC_W'(1);
                    if (state_q == ST_KILL) begin
                        kill_cnt_d = kill_cnt_q - KILL_CNT_W'(1);
                        if (kill_cnt_q == KILL_CNT_W'(1)) begin
                            state_d = ST_RUN;
                        end
                    end
                end
            end
        endcase
    end

    // Controller state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_RUN;
            pc_q          <= RESET_PC;
            pend_target_q <= '0;
            pend_v_q      <= 1'b0;
            kill_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pend_target_q <= pend_target_d;
            pend_v_q      <= pend_v_d;
            kill_cnt_q    <= kill_cnt_d;
        end
    end

    // A fetch accepted in the redirect cycle itself is wrong-path, so it never enters.
    fetch_valid_pipe #(
        .DEPTH (IMEM_LAT)
    ) u_valid_pipe (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (accept & ~redir),
        .kill_i      (redir),
        .out_valid_o (pipe_valid)
    );

    assign bus.pc_o          = pc_q;
    assign bus.fetch_req_o   = ~rst & ~pend_v_q;
    assign bus.flush_o       = redir | (kill_cnt_q != '0);
    assign bus.fetch_valid_o = pipe_valid & (kill_cnt_q == '0);

`ifdef PC_REDIRECT_COUNT_EN
    logic [31:0] redirect_cnt_q, redirect_cnt_d;

    // Saturating count of honoured redirect cycles.
    always_comb begin
        redirect_cnt_d = redirect_cnt_q;
        if (redir && (redirect_cnt_q != 32'hFFFF_FFFF)) begin
            redirect_cnt_d = redirect_cnt_q + 32'd1;
        end
    end

    // Redirect counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            redirect_cnt_q <= '0;
        end else begin
            redirect_cnt_q <= redirect_cnt_d;
        end
    end

    assign redirect_cnt_o = redirect_cnt_q;
`else
`endif

endmodule : fetch_pc_ctrl
`default_nettype wire
